// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: walks CSR reads/writes for ecall, irq and mret, then redirects the PC.
// Latency: trap entry jumps in the 6th held cycle after accept, mret in the 4th.
// Backpressure: holds pc_reg and the pipeline while busy; requests outside IDLE are ignored.
module trap_ctrl #(
  parameter int          XLEN        = 32,
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MTVEC   = 12'h305,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            irq_i,
  input  logic            global_int_en_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            hold_flag_o,
  output logic            jump_flag_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            busy_o
);

  // Bit 3 of the state is the sequence kind (0 = trap entry, 1 = mret) so the
  // mstatus read/write and jump steps can be shared between both sequences.
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0000,
    S_W_MEPC   = 4'b0001,
    S_W_MCAUSE = 4'b0010,
    S_R_MTVEC  = 4'b0011,
    S_R_MS_E   = 4'b0100,
    S_W_MS_E   = 4'b0101,
    S_JUMP_E   = 4'b0110,
    S_R_MEPC   = 4'b1001,
    S_R_MS_M   = 4'b1100,
    S_W_MS_M   = 4'b1101,
    S_JUMP_M   = 4'b1110
  } state_t;

  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(32'h0000_000B);
  localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] ms_q, ms_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] ms_entry, ms_mret;

  // Entry stacks MIE into MPIE and disables interrupts; mret restores MIE and sets MPIE.
  assign ms_entry = {ms_q[XLEN-1:8], ms_q[3], ms_q[6:4], 1'b0, ms_q[2:0]};
  assign ms_mret  = {ms_q[XLEN-1:8], 1'b1, ms_q[6:4], ms_q[7], ms_q[2:0]};

  // State and latch registers; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      ms_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      ms_q     <= ms_d;
      target_q <= target_d;
    end
  end

  // Next-state: accept in IDLE by priority, then step through the fixed CSR sequence.
  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    ms_d     = ms_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (ecall_i) begin
          state_d = S_W_MEPC;
          epc_d   = inst_addr_i;
          cause_d = CAUSE_ECALL;
        end else if (mret_i) begin
          state_d = S_R_MEPC;
          epc_d   = inst_addr_i;
        end else if (irq_i && global_int_en_i) begin
          state_d = S_W_MEPC;
          epc_d   = inst_addr_i;
          cause_d = CAUSE_IRQ;
        end
      end
      S_W_MEPC:   state_d = S_W_MCAUSE;
      S_W_MCAUSE: state_d = S_R_MS_E;
      S_R_MS_E, S_R_MS_M: begin
        ms_d    = csr_rdata_i;
        state_d = state_t'({state_q[3], 3'b101});
      end
      S_W_MS_E:   state_d = S_R_MTVEC;
      S_W_MS_M:   state_d = S_JUMP_M;
      S_R_MTVEC: begin
        target_d = csr_rdata_i & ALIGN_MASK;
        state_d  = S_JUMP_E;
      end
      S_R_MEPC: begin
        target_d = csr_rdata_i & ALIGN_MASK;
        state_d  = S_R_MS_M;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; forced quiet while reset is high.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_addr_o  = '0;
    csr_wdata_o = '0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = XLEN'(CSR_MEPC);
        csr_wdata_o = epc_q;
      end
      S_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = XLEN'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
      end
      S_R_MS_E, S_R_MS_M: csr_addr_o = XLEN'(CSR_MSTATUS);
      S_W_MS_E: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = XLEN'(CSR_MSTATUS);
        csr_wdata_o = ms_entry;
      end
      S_W_MS_M: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = XLEN'(CSR_MSTATUS);
        csr_wdata_o = ms_mret;
      end
      S_R_MTVEC: csr_addr_o = XLEN'(CSR_MTVEC);
      S_R_MEPC:  csr_addr_o = XLEN'(CSR_MEPC);
      S_JUMP_E, S_JUMP_M: begin
        jump_flag_o = 1'b1;
        jump_addr_o = target_q;
      end
      default: ;
    endcase
    if (rst) begin
      csr_we_o    = 1'b0;
      csr_addr_o  = '0;
      csr_wdata_o = '0;
      jump_flag_o = 1'b0;
      jump_addr_o = '0;
      busy_o      = 1'b0;
    end
    hold_flag_o = busy_o;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer that initiates the CSR accesses and PC redirects around machine-mode traps.
- Drives csr_reg's single access port (we/addr/wdata, reads rdata) and pc_reg's hold_flag/jump_flag/jump_addr inputs.
- Handles ecall, external interrupt and mret by walking a fixed sequence of CSR reads and writes, then issuing a one-cycle jump.
- Sits between the execute stage and the pc_reg/csr_reg pair.

Parameters:
- XLEN, 32, data/address width.
- CSR_MSTATUS, 12'h300, mstatus address.
- CSR_MTVEC, 12'h305, mtvec address.
- CSR_MEPC, 12'h341, mepc address.
- CSR_MCAUSE, 12'h342, mcause address.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- ecall_i  input  1  execute stage holds an ecall this cycle.
- mret_i  input  1  execute stage holds an mret this cycle.
- irq_i  input  1  external interrupt request, level.
- global_int_en_i  input  1  mstatus.MIE from csr_reg.
- inst_addr_i  input  XLEN  PC of the instruction in execute.
- csr_rdata_i  input  XLEN  csr_reg read data; combinational from csr_addr_o.
- csr_we_o  output  1  1 = write, 0 = read.
- csr_addr_o  output  XLEN  CSR address, zero-extended.
- csr_wdata_o  output  XLEN  CSR write data.
- hold_flag_o  output  1  stall pc_reg and the pipeline.
- jump_flag_o  output  1  redirect pc_reg this cycle.
- jump_addr_o  output  XLEN  redirect target.
- busy_o  output  1  sequence in progress.

Behaviour:
- Reset, synchronous: state=IDLE; all outputs 0; epc, cause, mstatus and target latches 0.
- Reset asserted mid-sequence aborts at the next edge. No further CSR writes occur; CSR writes already committed are not undone.
- Acceptance happens in IDLE only. Priority: ecall_i > mret_i > (irq_i && global_int_en_i).
- On acceptance, latch epc = inst_addr_i. Latch cause = 32'h0000000B for ecall, 32'h8000000B for irq.
- Requests arriving outside IDLE are ignored. irq is level, so it is re-evaluated on return to IDLE.
- hold_flag_o = busy_o = (state != IDLE). The accept cycle itself is not held.
- In IDLE and all read states: csr_we_o=0; csr_wdata_o=0.
- Trap entry state sequence, one cycle each:
  - W_MEPC: we=1, addr=MEPC, wdata=epc.
  - W_MCAUSE: we=1, addr=MCAUSE, wdata=cause.
  - R_MSTATUS: we=0, addr=MSTATUS; latch rdata into ms.
  - W_MSTATUS: we=1, addr=MSTATUS, wdata = ms with bit7 (MPIE) = ms[3] and bit3 (MIE) = 0; other bits unchanged.
  - R_MTVEC: we=0, addr=MTVEC; latch target = rdata & ~32'h3.
  - JUMP: jump_flag_o=1, jump_addr_o=target; then IDLE.
- mret state sequence:
  - R_MEPC: we=0, addr=MEPC; latch target = rdata & ~32'h3.
  - R_MSTATUS: latch ms.
  - W_MSTATUS: wdata = ms with bit3 = ms[7] and bit7 = 1.
  - JUMP: as above.
- Latency from accept edge to jump_flag_o high: trap entry 6 cycles (jump in the 6th held cycle); mret 4 cycles.
- jump_flag_o is high exactly one cycle. jump_addr_o = 0 whenever jump_flag_o = 0.
- Back-to-back traps: an irq pending at JUMP→IDLE can be accepted in the following IDLE cycle only if global_int_en_i = 1. It is 0 after entry, so no nesting.
- A single FSM variable carries a kind bit (entry/mret) to share the R_MSTATUS/W_MSTATUS/JUMP states.

Test Plan:
- Reset: rst=1 for 3 cycles mid-sequence → all outputs 0, state IDLE next cycle, no CSR write while rst=1.
- ecall at inst_addr=0x0000_0100, mstatus=0x0000_0008, mtvec=0x0000_0201:
  - Writes, in order: mepc←0x100, mcause←0xB, mstatus←0x0000_0080.
  - jump_addr=0x0000_0200 on the 6th cycle after accept.
  - hold high for 6 cycles.
- irq=1, global_int_en=0 for 20 cycles → no activity. Then global_int_en=1 at inst_addr=0x44 → mcause←0x8000_000B, mepc←0x44.
- mret with mepc=0x0000_0104, mstatus=0x0000_0080 → mstatus←0x0000_0088; jump to 0x104 on the 4th cycle; jump_flag pulse width 1.
- ecall and irq in the same cycle (MIE=1) → ecall sequence (mcause 0xB). irq held high, but MIE written 0, so no second trap.
- ecall_i pulsed during W_MCAUSE → ignored; exactly one sequence and one jump.
